gol_row_scheduler: RTL and testbench

//   Sequencer that drives the select/enable inputs of the 3-to-8 row decoder
//   in the game-of-life board. On a start request it walks rows 0..ROWS-1.

---
 rtl/gol_row_scheduler.sv | 136 +++++++++++++
 tb/tb_gol_row_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_row_scheduler.sv
// Row sequencer for the game-of-life board: walks rows 0..ROWS-1, dwells on each,
// then hands the row to the update datapath. Optional macro: GOL_SCHED_CONTINUOUS_EN.
module gol_row_scheduler #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned DWELL   = 4,
    parameter int unsigned FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               row_ready,
    output logic               dec_ena,
    output logic [2:0]         dec_sel,
    output logic               row_valid,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frame_count,
    output logic [1:0]         dbg_state_o
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               dec_ena_q, dec_ena_d;
    logic               row_valid_q, row_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Handshake: row_valid stays high in WAIT until row_ready is sampled high at a
    // rising edge; that edge completes the transfer. row_ready is ignored otherwise.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (row_ready) begin
                    if (row_q == 3'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        row_d   = row_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                row_d = 3'd0;
                cnt_d = '0;
`ifdef GOL_SCHED_CONTINUOUS_EN
                state_d = S_SCAN;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                row_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every transition above, including the move into DONE.
        if (abort) begin
            state_d = S_IDLE;
            row_d   = 3'd0;
            cnt_d   = '0;
        end

        if (state_d == S_DONE) begin
            frame_d = frame_q + FRAME_W'(1);
        end

        dec_ena_d   = (state_d == S_SCAN) || (state_d == S_WAIT);
        row_valid_d = (state_d == S_WAIT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= 3'd0;
            cnt_q       <= '0;
            frame_q     <= '0;
            dec_ena_q   <= 1'b0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            dec_ena_q   <= dec_ena_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dec_ena     = dec_ena_q;
    assign dec_sel     = row_q;
    assign row_valid   = row_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gol_row_scheduler.sv
// Bench for gol_row_scheduler: two instances (8 rows/dwell 4, and 2 rows/dwell 1/2-bit
// frame count) driven in lockstep and checked against a row/elapsed-cycle model.
module tb_gol_row_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, row_ready = 1'b0;

    logic ena1, val1, busy1, done1;
    logic [2:0] sel1;
    logic [15:0] fc1;
    logic [1:0] st1;
    logic ena2, val2, busy2, done2;
    logic [2:0] sel2;
    logic [1:0] fc2;
    logic [1:0] st2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gol_row_scheduler #(.ROWS(8), .DWELL(4), .FRAME_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .row_ready(row_ready),
        .dec_ena(ena1), .dec_sel(sel1), .row_valid(val1), .busy(busy1), .done(done1),
        .frame_count(fc1), .dbg_state_o(st1)
    );

    gol_row_scheduler #(.ROWS(2), .DWELL(1), .FRAME_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .row_ready(row_ready),
        .dec_ena(ena2), .dec_sel(sel2), .row_valid(val2), .busy(busy2), .done(done2),
        .frame_count(fc2), .dbg_state_o(st2)
    );

    // Reference model: "active" = decoder driving a row, "elapsed" = SCAN cycles spent
    // on the current row (row is valid once elapsed reaches dwell), "finishing" = done cycle.
    typedef struct {
        bit active;
        bit finishing;
        int row;
        int elapsed;
        int frames;
    } model_t;

    model_t m1, m2;

    typedef struct {
        logic [2:0] sar;
        logic       ena;
        logic [2:0] sel;
        logic       val;
        logic       busy;
        logic       done;
        logic [1:0] fc;
        logic       chk_sel;
    } vec_t;

    vec_t tbl[10];
    logic [1:0] exp_q[$];

    function automatic vec_t mk(input logic [2:0] sar, input logic ena, input logic [2:0] sel,
                                input logic val, input logic busy, input logic done,
                                input logic [1:0] fc, input logic chk_sel);
        vec_t v;
        v.sar = sar; v.ena = ena; v.sel = sel; v.val = val;
        v.busy = busy; v.done = done; v.fc = fc; v.chk_sel = chk_sel;
        return v;
    endfunction

    function automatic model_t model_step(input model_t m, input int rows, input int dwell,
                                          input int fw, input logic s, input logic a,
                                          input logic r);
        model_t n = m;
        if (a) begin
            n.active = 0; n.finishing = 0; n.row = 0; n.elapsed = 0;
        end else if (m.finishing) begin
            n.finishing = 0; n.row = 0; n.elapsed = 0;
`ifdef GOL_SCHED_CONTINUOUS_EN
            n.active = 1;
`else
            n.active = 0;
`endif
        end else if (!m.active) begin
            if (s) begin
                n.active = 1; n.row = 0; n.elapsed = 0;
            end
        end else if (m.elapsed < dwell) begin
            n.elapsed = m.elapsed + 1;
        end else if (r) begin
            if (m.row == rows - 1) begin
                n.active = 0;
                n.finishing = 1;
                n.frames = (m.frames + 1) % (1 << fw);
            end else begin
                n.row = m.row + 1;
                n.elapsed = 0;
            end
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.active = 0; m.finishing = 0; m.row = 0; m.elapsed = 0; m.frames = 0;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input string tag, input logic ena, input logic [2:0] sel,
                           input logic val, input logic bsy, input logic dn,
                           input logic [31:0] fc, input model_t m, input int dwell);
        check({tag, "_dec_ena"}, 32'(ena), 32'(m.active));
        check({tag, "_row_valid"}, 32'(val), 32'(m.active && (m.elapsed == dwell)));
        check({tag, "_busy"}, 32'(bsy), 32'(m.active || m.finishing));
        check({tag, "_done"}, 32'(dn), 32'(m.finishing));
        check({tag, "_frame_count"}, fc, m.frames);
        if (!m.finishing) check({tag, "_dec_sel"}, 32'(sel), m.row);
    endtask

    task automatic cmp_models();
        cmp_one("d1", ena1, sel1, val1, busy1, done1, 32'(fc1), m1, 4);
        cmp_one("d2", ena2, sel2, val2, busy2, done2, 32'(fc2), m2, 1);
    endtask

    task automatic tick(input logic s, input logic a, input logic r);
        start = s; abort = a; row_ready = r;
        @(posedge clk);
        m1 = model_step(m1, 8, 4, 16, s, a, r);
        m2 = model_step(m2, 2, 1, 2, s, a, r);
        #1;
        cmp_models();
    endtask

    // Reset is asserted mid-cycle and outputs are checked before the next clock edge.
    task automatic do_reset();
        start = 0; abort = 0; row_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        m1 = model_reset();
        m2 = model_reset();
        check("rst_dec_ena", 32'(ena1), 0);
        check("rst_dec_sel", 32'(sel1), 0);
        check("rst_row_valid", 32'(val1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_frame_count", 32'(fc1), 0);
        cmp_models();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int hold[8];
        int bc, dc, saved_fc, idle_seen;

        m1 = model_reset();
        m2 = model_reset();
        #3;
        do_reset();

        // Directed table on the 2-row / dwell-1 instance.
        tbl[0] = mk(3'b100, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        tbl[1] = mk(3'b000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        tbl[2] = mk(3'b000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        tbl[3] = mk(3'b001, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        tbl[4] = mk(3'b001, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        tbl[5] = mk(3'b001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
`ifdef GOL_SCHED_CONTINUOUS_EN
        tbl[6] = mk(3'b000, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
        tbl[7] = mk(3'b100, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
`else
        tbl[6] = mk(3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        tbl[7] = mk(3'b100, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
`endif
        tbl[8] = mk(3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        tbl[9] = mk(3'b110, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].sar[2], tbl[i].sar[1], tbl[i].sar[0]);
            check($sformatf("tbl%0d_dec_ena", i), 32'(ena2), 32'(tbl[i].ena));
            check($sformatf("tbl%0d_row_valid", i), 32'(val2), 32'(tbl[i].val));
            check($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done2), 32'(tbl[i].done));
            check($sformatf("tbl%0d_frame_count", i), 32'(fc2), 32'(tbl[i].fc));
            if (tbl[i].chk_sel) check($sformatf("tbl%0d_dec_sel", i), 32'(sel2), 32'(tbl[i].sel));
        end

`ifndef GOL_SCHED_CONTINUOUS_EN
        // Full frame with row_ready tied high: 8 rows x 5 cycles plus one done cycle.
        do_reset();
        for (int i = 0; i < 8; i++) hold[i] = 0;
        bc = 0; dc = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (k = 0; k < 100 && busy1; k++) begin
            bc++;
            if (done1) dc++;
            if (ena1) hold[sel1]++;
            tick(1'b0, 1'b0, 1'b1);
        end
        check("t1_busy_cycles", bc, 41);
        check("t1_done_pulses", dc, 1);
        check("t1_frame_count", 32'(fc1), 1);
        for (int i = 0; i < 8; i++) check($sformatf("t1_row%0d_hold", i), hold[i], 5);

        // Stall at row 3 for 10 cycles.
        tick(1'b1, 1'b0, 1'b1);
        for (k = 0; k < 100 && !(ena1 && sel1 == 3'd3); k++) tick(1'b0, 1'b0, 1'b1);
        for (k = 0; k < 20 && !val1; k++) tick(1'b0, 1'b0, 1'b0);
        check("t2_reached_wait_row3", 32'(val1 && sel1 == 3'd3), 1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check("t2_hold_sel", 32'(sel1), 3);
            check("t2_hold_valid", 32'(val1), 1);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("t2_advance_sel", 32'(sel1), 4);
        check("t2_advance_valid", 32'(val1), 0);
        for (k = 0; k < 100 && busy1; k++) tick(1'b0, 1'b0, 1'b1);
        check("t2_frame_count", 32'(fc1), 2);

        // Abort while scanning row 5.
        saved_fc = int'(fc1);
        tick(1'b1, 1'b0, 1'b1);
        for (k = 0; k < 100 && !(ena1 && !val1 && sel1 == 3'd5); k++) tick(1'b0, 1'b0, 1'b1);
        check("t3_reached_row5", 32'(sel1), 5);
        tick(1'b0, 1'b1, 1'b1);
        check("t3_dec_ena", 32'(ena1), 0);
        check("t3_dec_sel", 32'(sel1), 0);
        check("t3_busy", 32'(busy1), 0);
        check("t3_done", 32'(done1), 0);
        check("t3_frame_count", 32'(fc1), saved_fc);

        // Start pulsed while busy at row 2 is dropped.
        saved_fc = int'(fc1);
        tick(1'b1, 1'b0, 1'b1);
        for (k = 0; k < 100 && !(ena1 && sel1 == 3'd2); k++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        dc = 0;
        for (k = 0; k < 100 && busy1; k++) begin
            if (done1) dc++;
            tick(1'b0, 1'b0, 1'b1);
        end
        check("t4_done_pulses", dc, 1);
        check("t4_frame_count", 32'(fc1), saved_fc + 1);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_not_queued", 32'(busy1), 0);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of WAIT.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (k = 0; k < 20 && !val1; k++) tick(1'b0, 1'b0, 1'b0);
        check("t5_reached_wait", 32'(val1), 1);
        do_reset();

`ifdef GOL_SCHED_CONTINUOUS_EN
        // Free-running frames: 2-bit frame counter wraps, no idle gap between frames.
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        idle_seen = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (k = 0; k < 400 && exp_q.size() > 0; k++) begin
            if (done2) check("t6_frame_seq", 32'(fc2), 32'(exp_q.pop_front()));
            if (!busy1) idle_seen++;
            tick(1'b0, 1'b0, 1'b1);
        end
        check("t6_frames_seen", exp_q.size(), 0);
        check("t6_idle_cycles", idle_seen, 0);
        tick(1'b0, 1'b1, 1'b0);
        check("t6_abort_busy", 32'(busy1), 0);
`else
        idle_seen = 0;
        exp_q = '{};
        check("t6_queue_empty", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
